bcd_hour_counter: RTL and testbench
===================================

BCD_HOUR_COUNTER -- requirements
Module: bcd_hour_counter

Interface
REQ-001 The block SHALL have parameter MODE24, default 1, meaning 1 = 24-hour count 00..23 and 0 = 12-hour count 12,01..11 with AM/PM flag.
REQ-002 The block SHALL have port clk, input, 1 bit: single system clock, all state on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port tick, input, 1 bit: advance one hour when sampled high, one step per clk cycle.
REQ-005 The block SHALL have port dec, input, 1 bit: step back one hour when sampled high (time-setting button).
REQ-006 The block SHALL have port load, input, 1 bit: load the value on load_h10/load_h1/load_pm.
REQ-007 The block SHALL have ports load_h10, input, 4 bits, and load_h1, input, 4 bits: BCD tens and units of the load value.
REQ-008 The block SHALL have port load_pm, input, 1 bit: PM flag of the load value, ignored when MODE24=1.
REQ-009 The block SHALL have ports hour_10, output, 4 bits, and hour1, output, 4 bits: registered BCD tens and units.
REQ-010 The block SHALL have port pm, output, 1 bit: registered PM flag, constant 0 when MODE24=1.
REQ-011 The block SHALL have port day_carry, output, 1 bit: one-cycle pulse on forward day rollover.
REQ-012 The block SHALL have port load_err, output, 1 bit: one-cycle pulse when a load is rejected.

Function
REQ-013 All outputs SHALL be registered, and a change requested in cycle N SHALL appear after the clk edge ending cycle N (latency 1).
REQ-014 Priority SHALL be load > tick/dec; tick and dec high together without load SHALL leave the state unchanged.
REQ-015 Forward, MODE24=1: units SHALL increment, 09->10 and 19->20 SHALL carry into tens, and 23->00 SHALL wrap and pulse day_carry.
REQ-016 Forward, MODE24=0: the sequence SHALL be 12->01->...->09->10->11->12; 11->12 SHALL toggle pm; 11PM->12AM SHALL pulse day_carry.
REQ-017 Backward, MODE24=1: 00->23, 10->09 and 20->19 SHALL borrow correctly, and day_carry SHALL never pulse.
REQ-018 Backward, MODE24=0: 01->12 SHALL keep pm; 12->11 SHALL toggle pm; 10->09 SHALL borrow; day_carry SHALL never pulse.
REQ-019 A load SHALL be accepted only when both digits are valid BCD and the value is in range (00..23, or 01..12 in 12-hour mode).
REQ-020 An accepted load SHALL update hour_10, hour1 and pm, with no day_carry.
REQ-021 A rejected load SHALL leave the state unchanged and pulse load_err for exactly one cycle.
REQ-022 The state SHALL never leave the legal range for any input sequence.
REQ-023 Digit arithmetic SHALL be 4-bit BCD only, with no binary intermediate wider than 4 bits per digit.

Reset
REQ-024 When rst is low, the block SHALL immediately force hour_10=0, hour1=0, pm=0 (MODE24=1), or hour_10=1, hour1=2, pm=0 (MODE24=0, 12 AM).
REQ-025 When rst is low, day_carry and load_err SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL override any pending tick, dec or load, and the first step SHALL occur on the first rising clk edge after rst is released.

Configuration
REQ-027 With macro HOUR_ALARM_EN defined, the block SHALL add inputs alarm_set (1 bit), alarm_h10 (4 bits), alarm_h1 (4 bits) and alarm_pm (1 bit), plus output alarm_hit (1 bit).
REQ-028 With HOUR_ALARM_EN defined, alarm_set SHALL store the alarm value using the same validity rule as load, and an invalid value SHALL be ignored without a load_err pulse.
REQ-029 With HOUR_ALARM_EN defined, alarm_hit SHALL pulse one cycle when a tick or load makes the state equal to the stored alarm; dec SHALL never raise alarm_hit.
REQ-030 With HOUR_ALARM_EN defined, reset SHALL clear the stored alarm to the reset time value, with the alarm disabled until the first alarm_set.
REQ-031 Without HOUR_ALARM_EN, the alarm ports and logic SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-032 MODE24=1, 24 ticks from reset -> sequence 00..23 then 00, with day_carry high only on the 23->00 cycle.
REQ-033 MODE24=0, 24 ticks from reset -> 12AM, 01..11AM, 12PM, 01..11PM, then 12AM; pm toggles at 11->12; day_carry pulses once.
REQ-034 MODE24=1, dec from 00 -> 23, then dec -> 22, then dec repeated to 19 -> 20->19 borrow is correct; day_carry stays 0 throughout.
REQ-035 Load 2/4 (24h), then load 1/A, then load 0/0 in 12-hour mode -> each rejected with a single load_err pulse and state unchanged; load 1/7 (24h) -> 17.
REQ-036 Load, tick and dec high together -> load value wins; tick and dec high together -> no change; rst low mid-run -> 00 (or 12 AM) immediately, with no day_carry.
REQ-037 With HOUR_ALARM_EN defined: set alarm 07, run ticks from 05 -> alarm_hit pulses on the 06->07 cycle only; dec from 08 to 07 -> no alarm_hit.

Source files
------------

// File: rtl/bcd_hour_counter.sv
// bcd_hour_counter: BCD hour-of-day counter with tick/dec stepping, checked load and optional alarm.
//
// Optional feature macro: HOUR_ALARM_EN adds a one-hour alarm compare.
//
// Parameter:
//   MODE24    1 = 24-hour count 00..23, 0 = 12-hour count 12,01..11 with AM/PM flag
// Ports:
//   clk       system clock, all state on rising edge
//   rst       asynchronous active-low reset
//   tick      advance one hour
//   dec       step back one hour
//   load      load load_h10/load_h1/load_pm (wins over tick/dec)
//   load_h10  BCD tens of load value
//   load_h1   BCD units of load value
//   load_pm   PM flag of load value (ignored in 24-hour mode)
//   alarm_set alarm_h10 alarm_h1 alarm_pm alarm_hit   (HOUR_ALARM_EN only)
//   hour_10   registered BCD tens
//   hour1     registered BCD units
//   pm        registered PM flag (0 in 24-hour mode)
//   day_carry one-cycle pulse on forward day rollover
//   load_err  one-cycle pulse when a load is rejected
module bcd_hour_counter #(
    parameter bit MODE24 = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       dec,
    input  logic       load,
    input  logic [3:0] load_h10,
    input  logic [3:0] load_h1,
    input  logic       load_pm,
`ifdef HOUR_ALARM_EN
    input  logic       alarm_set,
    input  logic [3:0] alarm_h10,
    input  logic [3:0] alarm_h1,
    input  logic       alarm_pm,
    output logic       alarm_hit,
`endif
    output logic [3:0] hour_10,
    output logic [3:0] hour1,
    output logic       pm,
    output logic       day_carry,
    output logic       load_err
);
    localparam logic [3:0] RST_H10 = MODE24 ? 4'd0 : 4'd1;
    localparam logic [3:0] RST_H1  = MODE24 ? 4'd0 : 4'd2;

    logic [3:0] h10_q, h10_d, h1_q, h1_d;
    logic       pm_q, pm_d, dc_q, dc_d, le_q, le_d;
    logic [3:0] f10, f1, b10, b1;
    logic       fpm, bpm, fc, ld_ok;

    // Legal-range check shared by load and alarm_set.
    function automatic logic valid_hour(input logic [3:0] t, input logic [3:0] u);
        return (u <= 4'd9) && (MODE24 ? (t < 4'd2 || (t == 4'd2 && u <= 4'd3))
                                      : ((t == 4'd0 && u != 4'd0) || (t == 4'd1 && u <= 4'd2)));
    endfunction

    assign ld_ok = valid_hour(load_h10, load_h1);

    // Forward and backward successors, computed digit-wise in BCD.
    always_comb begin
        f10 = h10_q;
        f1  = h1_q + 4'd1;
        fpm = pm_q;
        fc  = 1'b0;
        b10 = h10_q;
        b1  = h1_q - 4'd1;
        bpm = pm_q;
        if (MODE24) begin
            if (h10_q == 4'd2 && h1_q == 4'd3) begin
                f10 = 4'd0;
                f1  = 4'd0;
                fc  = 1'b1;
            end else if (h1_q == 4'd9) begin
                f10 = h10_q + 4'd1;
                f1  = 4'd0;
            end
            if (h10_q == 4'd0 && h1_q == 4'd0) begin
                b10 = 4'd2;
                b1  = 4'd3;
            end else if (h1_q == 4'd0) begin
                b10 = h10_q - 4'd1;
                b1  = 4'd9;
            end
        end else begin
            if (h10_q == 4'd1 && h1_q == 4'd2) begin
                f10 = 4'd0;
                f1  = 4'd1;
            end else if (h10_q == 4'd1 && h1_q == 4'd1) begin
                f1  = 4'd2;
                fpm = ~pm_q;
                fc  = pm_q;
            end else if (h1_q == 4'd9) begin
                f10 = 4'd1;
                f1  = 4'd0;
            end
            if (h10_q == 4'd0 && h1_q == 4'd1) begin
                b10 = 4'd1;
                b1  = 4'd2;
            end else if (h10_q == 4'd1 && h1_q == 4'd2) begin
                b1  = 4'd1;
                bpm = ~pm_q;
            end else if (h1_q == 4'd0) begin
                b10 = 4'd0;
                b1  = 4'd9;
            end
        end
    end

    always_comb begin
        h10_d = h10_q;
        h1_d  = h1_q;
        pm_d  = pm_q;
        dc_d  = 1'b0;
        le_d  = 1'b0;
        if (load) begin
            if (ld_ok) begin
                h10_d = load_h10;
                h1_d  = load_h1;
                pm_d  = MODE24 ? 1'b0 : load_pm;
            end else begin
                le_d = 1'b1;
            end
        end else if (tick && !dec) begin
            h10_d = f10;
            h1_d  = f1;
            pm_d  = fpm;
            dc_d  = fc;
        end else if (dec && !tick) begin
            h10_d = b10;
            h1_d  = b1;
            pm_d  = bpm;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h10_q <= RST_H10;
            h1_q  <= RST_H1;
            pm_q  <= 1'b0;
            dc_q  <= 1'b0;
            le_q  <= 1'b0;
        end else begin
            h10_q <= h10_d;
            h1_q  <= h1_d;
            pm_q  <= pm_d;
            dc_q  <= dc_d;
            le_q  <= le_d;
        end
    end

    assign hour_10   = h10_q;
    assign hour1     = h1_q;
    assign pm        = pm_q;
    assign day_carry = dc_q;
    assign load_err  = le_q;

`ifdef HOUR_ALARM_EN
    logic [3:0] a10_q, a1_q;
    logic       apm_q, aen_q, ah_q, ah_d;

    // Only forward steps and accepted loads can hit; dec never does.
    assign ah_d = aen_q && ((load && ld_ok) || (!load && tick && !dec))
                  && h10_d == a10_q && h1_d == a1_q && pm_d == apm_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a10_q <= RST_H10;
            a1_q  <= RST_H1;
            apm_q <= 1'b0;
            aen_q <= 1'b0;
            ah_q  <= 1'b0;
        end else begin
            ah_q <= ah_d;
            if (alarm_set && valid_hour(alarm_h10, alarm_h1)) begin
                a10_q <= alarm_h10;
                a1_q  <= alarm_h1;
                apm_q <= MODE24 ? 1'b0 : alarm_pm;
                aen_q <= 1'b1;
            end
        end
    end

    assign alarm_hit = ah_q;
`endif
endmodule

// File: tb/tb_bcd_hour_counter.sv
// tb_bcd_hour_counter: scoreboard bench for both count modes of bcd_hour_counter.
module tb_bcd_hour_counter;
    typedef struct packed {
        logic [3:0] h10;
        logic [3:0] h1;
        logic       pm;
        logic       dc;
        logic       le;
        logic       ah;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       t24 = 0, d24 = 0, l24 = 0, p24 = 0;
    logic       t12 = 0, d12 = 0, l12 = 0, p12 = 0;
    logic [3:0] a24 = 0, b24 = 0, a12 = 0, b12 = 0;
    logic [3:0] o10_24, o1_24, o10_12, o1_12;
    logic       pm24, dc24, le24, ah24, pm12, dc12, le12, ah12;
    logic       as24 = 0, ap24 = 0;
    logic [3:0] aa24 = 0, ab24 = 0;
    exp_t       q24[$];
    exp_t       q12[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    bcd_hour_counter #(.MODE24(1'b1)) dut24 (
        .clk(clk), .rst(rst), .tick(t24), .dec(d24), .load(l24),
        .load_h10(a24), .load_h1(b24), .load_pm(p24),
`ifdef HOUR_ALARM_EN
        .alarm_set(as24), .alarm_h10(aa24), .alarm_h1(ab24), .alarm_pm(ap24), .alarm_hit(ah24),
`endif
        .hour_10(o10_24), .hour1(o1_24), .pm(pm24), .day_carry(dc24), .load_err(le24)
    );

    bcd_hour_counter #(.MODE24(1'b0)) dut12 (
        .clk(clk), .rst(rst), .tick(t12), .dec(d12), .load(l12),
        .load_h10(a12), .load_h1(b12), .load_pm(p12),
`ifdef HOUR_ALARM_EN
        .alarm_set(1'b0), .alarm_h10(4'd0), .alarm_h1(4'd0), .alarm_pm(1'b0), .alarm_hit(ah12),
`endif
        .hour_10(o10_12), .hour1(o1_12), .pm(pm12), .day_carry(dc12), .load_err(le12)
    );

`ifndef HOUR_ALARM_EN
    assign ah24 = 1'b0;
    assign ah12 = 1'b0;
`endif

    function automatic exp_t mk(input int hr, input logic p, input logic dc, input logic le, input logic ah);
        return '{h10: 4'(hr / 10), h1: 4'(hr % 10), pm: p, dc: dc, le: le, ah: ah};
    endfunction

    function automatic exp_t got24();
        return '{h10: o10_24, h1: o1_24, pm: pm24, dc: dc24, le: le24, ah: ah24};
    endfunction

    function automatic exp_t got12();
        return '{h10: o10_12, h1: o1_12, pm: pm12, dc: dc12, le: le12, ah: ah12};
    endfunction

    task automatic check(input string nm, input exp_t act, input exp_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h%0h pm=%0b dc=%0b le=%0b ah=%0b, want %0h%0h pm=%0b dc=%0b le=%0b ah=%0b",
                     nm, act.h10, act.h1, act.pm, act.dc, act.le, act.ah,
                     exp.h10, exp.h1, exp.pm, exp.dc, exp.le, exp.ah);
        end
    endtask

    // Monitor: each registered result appears one edge after its stimulus.
    always @(posedge clk) begin
        #1;
        if (q24.size() != 0) check("h24", got24(), q24.pop_front());
        if (q12.size() != 0) check("h12", got12(), q12.pop_front());
    end

    task automatic c24(input logic t, input logic d, input logic l, input logic [3:0] a, input logic [3:0] b,
                       input logic p, input int hr, input logic dc, input logic le, input logic ah = 1'b0);
        t24 = t; d24 = d; l24 = l; a24 = a; b24 = b; p24 = p;
        q24.push_back(mk(hr, 1'b0, dc, le, ah));
        @(negedge clk);
        t24 = 0; d24 = 0; l24 = 0;
    endtask

    task automatic c12(input logic t, input logic d, input logic l, input logic [3:0] a, input logic [3:0] b,
                       input logic p, input int hr, input logic epm, input logic dc, input logic le);
        t12 = t; d12 = d; l12 = l; a12 = a; b12 = b; p12 = p;
        q12.push_back(mk(hr, epm, dc, le, 1'b0));
        @(negedge clk);
        t12 = 0; d12 = 0; l12 = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst24", got24(), mk(0, 0, 0, 0, 0));
        check("rst12", got12(), mk(12, 0, 0, 0, 0));
        rst = 1'b1;
        // 24-hour: full day of ticks, carry only on 23->00
        c24(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 24; i++) c24(1, 0, 0, 0, 0, 0, i % 24, i == 24, 0);
        for (int h = 23; h >= 19; h--) c24(0, 1, 0, 0, 0, 0, h, 0, 0);
        c24(0, 0, 1, 4'd2, 4'd4, 0, 19, 0, 1);
        c24(0, 0, 0, 0, 0, 0, 19, 0, 0);
        c24(0, 0, 1, 4'd1, 4'hA, 0, 19, 0, 1);
        c24(0, 0, 1, 4'd1, 4'd7, 1, 17, 0, 0);
        c24(0, 0, 1, 4'd0, 4'd9, 0, 9, 0, 0);
        c24(1, 0, 0, 0, 0, 0, 10, 0, 0);
        c24(0, 1, 0, 0, 0, 0, 9, 0, 0);
        c24(0, 0, 1, 4'd1, 4'd9, 0, 19, 0, 0);
        c24(1, 0, 0, 0, 0, 0, 20, 0, 0);
        c24(0, 1, 0, 0, 0, 0, 19, 0, 0);
        c24(1, 1, 1, 4'd0, 4'd5, 0, 5, 0, 0);
        c24(1, 1, 0, 0, 0, 0, 5, 0, 0);
`ifdef HOUR_ALARM_EN
        as24 = 1; aa24 = 4'd0; ab24 = 4'd7;
        c24(0, 0, 0, 0, 0, 0, 5, 0, 0);
        aa24 = 4'd2; ab24 = 4'd5;
        c24(0, 0, 0, 0, 0, 0, 5, 0, 0);
        as24 = 0;
        c24(1, 0, 0, 0, 0, 0, 6, 0, 0, 0);
        c24(1, 0, 0, 0, 0, 0, 7, 0, 0, 1);
        c24(1, 0, 0, 0, 0, 0, 8, 0, 0, 0);
        c24(0, 1, 0, 0, 0, 0, 7, 0, 0, 0);
        c24(0, 0, 1, 4'd0, 4'd7, 0, 7, 0, 0, 1);
`endif
        // 12-hour: full day from 12 AM, pm flips at 11->12, one carry
        c12(0, 0, 0, 0, 0, 0, 12, 0, 0, 0);
        for (int i = 1; i <= 24; i++) begin
            automatic int h = i % 24;
            c12(1, 0, 0, 0, 0, 0, (h % 12 == 0) ? 12 : h % 12, h >= 12, i == 24, 0);
        end
        c12(0, 1, 0, 0, 0, 0, 11, 1, 0, 0);
        c12(0, 1, 0, 0, 0, 0, 10, 1, 0, 0);
        c12(0, 1, 0, 0, 0, 0, 9, 1, 0, 0);
        c12(0, 0, 1, 4'd0, 4'd1, 0, 1, 0, 0, 0);
        c12(0, 1, 0, 0, 0, 0, 12, 0, 0, 0);
        c12(0, 0, 1, 4'd0, 4'd0, 1, 12, 0, 0, 1);
        c12(0, 0, 1, 4'd1, 4'd3, 0, 12, 0, 0, 1);
        c12(0, 0, 1, 4'd1, 4'd2, 1, 12, 1, 0, 0);
        c12(0, 1, 0, 0, 0, 0, 11, 0, 0, 0);
        c12(1, 0, 0, 0, 0, 0, 12, 1, 0, 0);
        // Asynchronous reset mid-run, with a carrying tick pending
        c24(0, 0, 1, 4'd2, 4'd3, 0, 23, 0, 0);
        c12(0, 0, 1, 4'd1, 4'd1, 1, 11, 1, 0, 0);
        t24 = 1; t12 = 1;
        #2 rst = 1'b0;
        #1;
        check("arst24", got24(), mk(0, 0, 0, 0, 0));
        check("arst12", got12(), mk(12, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("hold24", got24(), mk(0, 0, 0, 0, 0));
        check("hold12", got12(), mk(12, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        q24.push_back(mk(1, 0, 0, 0, 0));
        q12.push_back(mk(1, 0, 0, 0, 0));
        @(negedge clk);
        t24 = 0; t12 = 0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (q24.size() != 0 || q12.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", q24.size(), q12.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
